// File: rtl/dual_input_debounce.sv
// rtl/dual_input_debounce.sv - two independent sync + debounce + rising-edge pulse channels
// Cleaned levels feed the downstream OR gate inputs.
module dual_input_debounce #(
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw1,
   input  logic raw2,
   output logic db1,
   output logic db2,
   output logic rise1,
   output logic rise2
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [1:0]            raw;
   logic [1:0]            sync_a;
   logic [1:0]            sync_b;
   logic [1:0]            db;
   logic [1:0]            rise;
   logic [1:0][CNT_W-1:0] cnt;

   assign raw = {raw2, raw1};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
         db     <= '0;
         rise   <= '0;
         cnt    <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         for (int i = 0; i < 2; i++) begin
            rise[i] <= 1'b0;
            if (sync_b[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == LIMIT) begin
               // level accepted; pulse only on the 0->1 direction
               db[i]   <= sync_b[i];
               rise[i] <= sync_b[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + ONE;
            end
         end
      end
   end

   assign db1   = db[0];
   assign db2   = db[1];
   assign rise1 = rise[0];
   assign rise2 = rise[1];

endmodule
